// File: rtl/wb_master_fft.sv
// ---------------------------------------------------------------------------
// wb_master_fft
//
// Wishbone master that runs one FFT frame on a memory-mapped FFT slave:
// clears the slave, streams N samples into its data register, polls the
// status register until the transform is ready (or gives up after
// poll_limit reads), then reads N results back and streams them out.
//
// Every transfer is followed by at least one idle strobe cycle. A registered
// read acknowledge from the slave can therefore never be mistaken for the
// acknowledge of the next transfer.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle frame request (ignored while busy)
//   busy, done, error       frame in progress, end-of-frame pulse,
//                           sticky poll timeout flag
//   CYC_O, STB_O, WE_O      Wishbone cycle, strobe, write enable
//   ADR_O, DAT_O            Wishbone byte address and write data
//   DAT_I, ACK_I            Wishbone read data and acknowledge
//   src_data/valid/ready    sample source stream (input to the FFT)
//   res_data/valid/ready    result sink stream (output of the FFT)
// ---------------------------------------------------------------------------
module wb_master_fft #(
    parameter int N                = 1024,
    parameter int Log2N            = 10,
    parameter int data_wordwidth   = 32,
    parameter int adress_wordwidth = 32,
    parameter int reg_control      = 0,
    parameter int reg_data         = 4,
    parameter int reg_status       = 8,
    parameter int reg_memory       = 12,
    parameter int poll_limit       = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        CYC_O,
    output logic                        STB_O,
    output logic                        WE_O,
    output logic [adress_wordwidth-1:0] ADR_O,
    output logic [data_wordwidth-1:0]   DAT_O,
    input  logic [data_wordwidth-1:0]   DAT_I,
    input  logic                        ACK_I,
    input  logic [data_wordwidth-1:0]   src_data,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic [data_wordwidth-1:0]   res_data,
    output logic                        res_valid,
    input  logic                        res_ready
);

    localparam int AW = adress_wordwidth;
    localparam int DW = data_wordwidth;
    localparam int KW = Log2N + 1;
    localparam int PW = $clog2(poll_limit + 1);

    localparam logic [AW-1:0] ADR_CONTROL = AW'(reg_control);
    localparam logic [AW-1:0] ADR_DATA    = AW'(reg_data);
    localparam logic [AW-1:0] ADR_STATUS  = AW'(reg_status);
    localparam logic [AW-1:0] ADR_MEMORY  = AW'(reg_memory);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLEAR = 4'd1,
        S_LOAD  = 4'd2,
        S_GAP   = 4'd3,
        S_POLL  = 4'd4,
        S_READ  = 4'd5,
        S_PUSH  = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    // Byte address of result word idx in the slave's result memory.
    function automatic logic [AW-1:0] mem_addr(input logic [KW-1:0] idx);
        mem_addr = ADR_MEMORY + (AW'(idx) << 2);
    endfunction

    // State and counters. ret_q is where the GAP cycle hands control next.
    state_t         state_q, state_d;
    state_t         ret_q, ret_d;
    logic [KW-1:0]  k_q, k_d;
    logic [PW-1:0]  poll_q, poll_d;

    // Registered outputs.
    logic           cyc_q, cyc_d;
    logic           stb_q, stb_d;
    logic           we_q, we_d;
    logic [AW-1:0]  adr_q, adr_d;
    logic [DW-1:0]  dat_q, dat_d;
    logic           src_ready_q, src_ready_d;
    logic [DW-1:0]  res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    // Combinational helpers: start a new transfer / retire the current one.
    logic           issue_s;
    logic           issue_we_s;
    logic [AW-1:0]  issue_adr_s;
    logic [DW-1:0]  issue_dat_s;
    logic           drop_s;
    logic           bus_ack_s;
    logic [KW-1:0]  k_inc_s;
    logic [PW-1:0]  poll_inc_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        k_d         = k_q;
        poll_d      = poll_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        issue_s     = 1'b0;
        issue_we_s  = 1'b0;
        issue_adr_s = {AW{1'b0}};
        issue_dat_s = {DW{1'b0}};
        drop_s      = 1'b0;
        // An acknowledge only counts while our own strobe is up.
        bus_ack_s   = stb_q & ACK_I;
        k_inc_s     = k_q + KW'(1'b1);
        poll_inc_s  = poll_q + PW'(1'b1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CLEAR;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    k_d         = {KW{1'b0}};
                    poll_d      = {PW{1'b0}};
                    res_valid_d = 1'b0;
                    issue_s     = 1'b1;
                    issue_we_s  = 1'b1;
                    issue_adr_s = ADR_CONTROL;
                    issue_dat_s = {DW{1'b0}};
                end else begin
                    busy_d = 1'b0;
                end
            end

            S_CLEAR: begin
                if (bus_ack_s) begin
                    drop_s  = 1'b1;
                    state_d = S_GAP;
                    ret_d   = S_LOAD;
                end else begin
                    drop_s = 1'b0;
                end
            end

            S_LOAD: begin
                if (!stb_q) begin
                    // src_ready_q is only high while no strobe is pending.
                    if (src_valid && src_ready_q) begin
                        issue_s     = 1'b1;
                        issue_we_s  = 1'b1;
                        issue_adr_s = ADR_DATA;
                        issue_dat_s = src_data;
                    end else begin
                        issue_s = 1'b0;
                    end
                end else if (ACK_I) begin
                    drop_s  = 1'b1;
                    state_d = S_GAP;
                    if (k_inc_s == KW'(N)) begin
                        k_d   = {KW{1'b0}};
                        ret_d = S_POLL;
                    end else begin
                        k_d   = k_inc_s;
                        ret_d = S_LOAD;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end

            S_GAP: begin
                // One strobe-free cycle, then launch whatever comes next.
                state_d = ret_q;
                case (ret_q)
                    S_POLL: begin
                        issue_s     = 1'b1;
                        issue_adr_s = ADR_STATUS;
                    end
                    S_READ: begin
                        issue_s     = 1'b1;
                        issue_adr_s = mem_addr(k_q);
                    end
                    S_ERR: begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end
                    default: begin
                        issue_s = 1'b0;
                    end
                endcase
            end

            S_POLL: begin
                if (bus_ack_s) begin
                    drop_s  = 1'b1;
                    state_d = S_GAP;
                    if (DAT_I[0]) begin
                        ret_d = S_READ;
                    end else begin
                        poll_d = poll_inc_s;
                        ret_d  = (poll_inc_s == PW'(poll_limit)) ? S_ERR : S_POLL;
                    end
                end else begin
                    drop_s = 1'b0;
                end
            end

            S_READ: begin
                if (bus_ack_s) begin
                    drop_s      = 1'b1;
                    res_data_d  = DAT_I;
                    res_valid_d = 1'b1;
                    state_d     = S_PUSH;
                end else begin
                    drop_s = 1'b0;
                end
            end

            S_PUSH: begin
                // The strobe is low here, which doubles as the inter-read gap.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    k_d         = k_inc_s;
                    if (k_q == KW'(N - 1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        issue_s     = 1'b1;
                        issue_adr_s = mem_addr(k_inc_s);
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end

            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_s) begin
            stb_d = 1'b1;
            we_d  = issue_we_s;
            adr_d = issue_adr_s;
            dat_d = issue_dat_s;
        end else if (drop_s) begin
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = {AW{1'b0}};
            dat_d = {DW{1'b0}};
        end else begin
            stb_d = stb_q;
        end

        cyc_d       = stb_d;
        src_ready_d = (state_d == S_LOAD) && !stb_d;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            k_q         <= {KW{1'b0}};
            poll_q      <= {PW{1'b0}};
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            src_ready_q <= 1'b0;
            res_data_q  <= {DW{1'b0}};
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            k_q         <= k_d;
            poll_q      <= poll_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            src_ready_q <= src_ready_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign CYC_O     = cyc_q;
    assign STB_O     = stb_q;
    assign WE_O      = we_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign src_ready = src_ready_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: doc/wb_master_fft.md
WB_MASTER_FFT -- requirements
Module: wb_master_fft

Parameters
REQ-001 N, 1024, FFT points per frame.
REQ-002 Log2N, 10, log2 of N.
REQ-003 data_wordwidth, 32, Wishbone data width.
REQ-004 adress_wordwidth, 32, Wishbone address width.
REQ-005 reg_control, 0; reg_data, 4; reg_status, 8; reg_memory, 12: slave byte offsets.
REQ-006 poll_limit, 65535, maximum status reads before timeout.

Interface
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  one-cycle request to process one frame; ignored while busy=1.
REQ-010 busy  out  1  high from the cycle after accepted start until done pulse.
REQ-011 done  out  1  one-cycle pulse at frame end.
REQ-012 error  out  1  sticky timeout flag, cleared by next accepted start.
REQ-013 CYC_O, STB_O, WE_O  out  1 each  Wishbone master cycle, strobe, write enable.
REQ-014 ADR_O  out  adress_wordwidth  byte address to slave.
REQ-015 DAT_O  out  data_wordwidth  write data to slave.
REQ-016 DAT_I  in  data_wordwidth  read data from slave.
REQ-017 ACK_I  in  1  slave acknowledge.
REQ-018 src_data  in  data_wordwidth; src_valid  in  1; src_ready  out  1  sample source stream.
REQ-019 res_data  out  data_wordwidth; res_valid  out  1; res_ready  in  1  result sink stream.

Function
REQ-020 States: IDLE, CLEAR, LOAD, GAP, POLL, READ, PUSH, DONE, ERR; all outputs registered.
REQ-021 IDLE->CLEAR on start; error cleared, sample counter k cleared, poll counter cleared.
REQ-022 CLEAR: write DAT_O=0 to ADR_O=reg_control; on ACK_I go to LOAD.
REQ-023 LOAD: src_ready=1 only when no strobe is pending; on src_valid&src_ready capture src_data and issue write to reg_data; on ACK_I increment k; after k reaches N go to POLL with k=0.
REQ-024 POLL: read reg_status; on ACK_I, if DAT_I[0]=1 go to READ, else increment poll counter and re-read; poll counter reaching poll_limit goes to ERR.
REQ-025 READ: read ADR_O=reg_memory+4*k; on ACK_I capture DAT_I into res_data, set res_valid, go to PUSH.
REQ-026 PUSH: hold res_data/res_valid until res_ready; on handshake k+1; if k was N-1 go to DONE, else READ.
REQ-027 DONE: done=1 one cycle, then IDLE; ERR: error=1, done=1 one cycle, then IDLE.
REQ-028 Transfer rule: STB_O and CYC_O rise together, held with stable ADR_O/WE_O/DAT_O until ACK_I; dropped in the cycle after ACK_I is sampled.
REQ-029 Every transfer is followed by at least one cycle with STB_O=0 (GAP), so a registered read ack cannot be mistaken for the next transfer's ack.
REQ-030 Write ACK is expected same cycle as STB_O; read ACK one cycle later; no fixed latency is assumed; wait indefinitely for ACK_I.
REQ-031 ACK_I with STB_O=0 is ignored.
REQ-032 k is Log2N+1 bits; address arithmetic done in adress_wordwidth bits, no wrap within a frame.
REQ-033 WE_O=0 and DAT_O=0 whenever STB_O=0 or a read is in progress.
REQ-034 start arriving in the DONE cycle is ignored.

Reset
REQ-035 rst_n=0 forces, immediately: state IDLE, counters 0, busy, done, error, CYC_O, STB_O, WE_O, src_ready, res_valid = 0, ADR_O, DAT_O, res_data = 0.
REQ-036 Reset mid-frame abandons the frame; no done pulse; after release the next start begins from CLEAR.

Verification
REQ-037 N=4, slave model acks writes same cycle, reads +1 cycle, status=1 on first poll, samples 1..4 -> writes to addr 0 (data 0), then 4,4,4,4 with data 1..4, one read of 8, reads 12,16,20,24, four results, done one cycle, busy low after.
REQ-038 status returns 0 three times then 1 -> exactly four reads of addr 8, frame completes normally.
REQ-039 poll_limit=5, status stuck 0 -> five status reads, error=1, done pulse, no result reads; next start clears error.
REQ-040 res_ready low 10 cycles on second result -> res_valid/res_data held stable, no Wishbone activity during stall.
REQ-041 src_valid gaps during LOAD and ACK_I delayed 3 cycles -> STB_O/ADR_O/DAT_O stable until ack, STB_O=0 at least one cycle between every transfer.
REQ-042 rst_n pulsed low during READ at k=2 -> all outputs 0 asynchronously, start after release restarts at CLEAR write to addr 0.
